// File: rtl/pc_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states and field widths.
package pc_fetch_stage_pkg;

    typedef enum logic [1:0] {
        FS_BOOT   = 2'd0,
        FS_RUN    = 2'd1,
        FS_HALTED = 2'd2
    } fetch_state_t;

    localparam int JUMP_FIELD_W = 26;
    localparam int IMM_W        = 16;
    localparam int PC_STEP      = 4;

endpackage

// File: rtl/pc_fetch_stage_next_pc.sv
// Combinational next-PC resolution: sequential PC+4 and the redirect target (jr > jump > branch).
module pc_fetch_stage_next_pc
    import pc_fetch_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]       pc,
    input  logic [ADDR_W-1:0]       if_pc_plus4,
    input  logic                    jr,
    input  logic [ADDR_W-1:0]       jr_target,
    input  logic                    jump,
    input  logic [JUMP_FIELD_W-1:0] jump_addr,
    input  logic [IMM_W-1:0]        br_imm,
    output logic [ADDR_W-1:0]       pc_seq,
    output logic [ADDR_W-1:0]       target,
    output logic                    misalign
);

    logic [ADDR_W-1:0] jr_pc;
    logic [ADDR_W-1:0] jump_pc;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] br_pc;

    assign pc_seq  = pc + ADDR_W'(PC_STEP);
    assign jr_pc   = {jr_target[ADDR_W-1:2], 2'b00};
    assign jump_pc = {if_pc_plus4[ADDR_W-1:28], jump_addr, 2'b00};
    // Sign-extend to full width first so the shift never drops the sign.
    assign br_off  = {{(ADDR_W-IMM_W){br_imm[IMM_W-1]}}, br_imm} << 2;
    assign br_pc   = if_pc_plus4 + br_off;

    assign target   = jr ? jr_pc : (jump ? jump_pc : br_pc);
    assign misalign = jr & (|jr_target[1:0]);

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID slot with valid/ready, redirect flush, sticky halt.
// Optional FETCH_PERF_EN adds saturating fetch/bubble counters.
module pc_fetch_stage
    import pc_fetch_stage_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          INSTR_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic [ADDR_W-1:0]       imem_addr,
    input  logic [INSTR_W-1:0]      imem_rdata,
    output logic                    if_valid,
    output logic [INSTR_W-1:0]      if_instr,
    output logic [ADDR_W-1:0]       if_pc,
    output logic [ADDR_W-1:0]       if_pc_plus4,
    input  logic                    id_ready,
    input  logic                    br_taken,
    input  logic [IMM_W-1:0]        br_imm,
    input  logic                    jump,
    input  logic [JUMP_FIELD_W-1:0] jump_addr,
    input  logic                    jr,
    input  logic [ADDR_W-1:0]       jr_target,
    input  logic                    halt,
`ifdef FETCH_PERF_EN
    output logic [31:0]             perf_fetched,
    output logic [31:0]             perf_bubbles,
`endif
    output logic                    misalign
);

    // state     | meaning
    // FS_BOOT   | one settling cycle after reset, no fetch
    // FS_RUN    | fetching; stall when slot full and decode not ready
    // FS_HALTED | pc frozen, slot drained once consumed; left only by reset

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_seq;
    logic [ADDR_W-1:0] target;
    logic              tgt_misalign;
    logic              advance;
    logic              redirect;
    logic              fetch;

    assign imem_addr = pc;
    assign advance   = !if_valid || id_ready;
    assign redirect  = (state == FS_RUN) && if_valid && id_ready && (jr || jump || br_taken);
    assign fetch     = (state == FS_RUN) && advance && !redirect && !halt;

    pc_fetch_stage_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
        .pc          (pc),
        .if_pc_plus4 (if_pc_plus4),
        .jr          (jr),
        .jr_target   (jr_target),
        .jump        (jump),
        .jump_addr   (jump_addr),
        .br_imm      (br_imm),
        .pc_seq      (pc_seq),
        .target      (target),
        .misalign    (tgt_misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FS_BOOT;
            pc          <= RESET_PC[ADDR_W-1:0];
            if_valid    <= 1'b0;
            if_instr    <= '0;
            if_pc       <= '0;
            if_pc_plus4 <= '0;
            misalign    <= 1'b0;
        end else begin
            misalign <= 1'b0;
            case (state)
                FS_BOOT: state <= FS_RUN;
                FS_RUN: begin
                    if (halt) state <= FS_HALTED;
                    if (redirect) begin
                        pc       <= target;
                        if_valid <= 1'b0;
                        misalign <= tgt_misalign;
                    end else if (fetch) begin
                        if_instr    <= imem_rdata;
                        if_pc       <= pc;
                        if_pc_plus4 <= pc_seq;
                        if_valid    <= 1'b1;
                        pc          <= pc_seq;
                    end else if (advance) begin
                        // halting with an empty or consumed slot: drain without fetching
                        if_valid <= 1'b0;
                    end
                end
                FS_HALTED: if (id_ready) if_valid <= 1'b0;
                default:   state <= FS_BOOT;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (fetch && perf_fetched != 32'hFFFF_FFFF) perf_fetched <= perf_fetched + 32'd1;
            if (redirect && perf_bubbles != 32'hFFFF_FFFF) perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: sequential fetch, stall, branch/jump/jr redirects, wrap, halt, reset.
module tb_pc_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        id_ready;
    logic        br_taken;
    logic [15:0] br_imm;
    logic        jump;
    logic [25:0] jump_addr;
    logic        jr;
    logic [31:0] jr_target;
    logic        halt;
    logic        misalign;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_5A00;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    pc_fetch_stage #(.ADDR_W(32), .RESET_PC(64'h100), .INSTR_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4),
        .id_ready    (id_ready),
        .br_taken    (br_taken),
        .br_imm      (br_imm),
        .jump        (jump),
        .jump_addr   (jump_addr),
        .jr          (jr),
        .jr_target   (jr_target),
        .halt        (halt),
`ifdef FETCH_PERF_EN
        .perf_fetched(perf_fetched),
        .perf_bubbles(perf_bubbles),
`endif
        .misalign    (misalign)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Slot holds a valid fetch of address a; pc has moved to a+4.
    task automatic check_slot(input string tag, input logic [31:0] a);
        check({tag, ".valid"}, 64'(if_valid), 64'd1);
        check({tag, ".pc"}, 64'(if_pc), 64'(a));
        check({tag, ".pc4"}, 64'(if_pc_plus4), 64'(a + 32'd4));
        check({tag, ".instr"}, 64'(if_instr), 64'(mem_word(a)));
        check({tag, ".addr"}, 64'(imem_addr), 64'(a + 32'd4));
    endtask

    task automatic clear_redirects();
        br_taken = 1'b0; jump = 1'b0; jr = 1'b0;
        br_imm = '0; jump_addr = '0; jr_target = '0;
    endtask

    initial begin
        rst_n = 1'b0; id_ready = 1'b1; halt = 1'b0;
        clear_redirects();
        #12;
        check("rst.valid", 64'(if_valid), 64'd0);
        check("rst.addr", 64'(imem_addr), 64'h100);
        check("rst.if_pc", 64'(if_pc), 64'd0);
        check("rst.instr", 64'(if_instr), 64'd0);
        check("rst.misalign", 64'(misalign), 64'd0);

        // sequential fetch after one BOOT cycle
        @(negedge clk); rst_n = 1'b1;
        step();
        check("boot.valid", 64'(if_valid), 64'd0);
        check("boot.addr", 64'(imem_addr), 64'h100);
        step(); check_slot("seq0", 32'h100);
        step(); check_slot("seq1", 32'h104);
        step(); check_slot("seq2", 32'h108);

        // stall three cycles
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); check_slot("stall", 32'h108);
        end
        // redirect inputs ignored while stalled
        jr = 1'b1; jr_target = 32'h3000;
        step(); check_slot("stall.jr", 32'h108);
        clear_redirects();
        id_ready = 1'b1;
        step(); check_slot("resume", 32'h10C);

        // j into region 0 -> 0x200
        jump = 1'b1; jump_addr = 26'h80;
        step();
        check("j.bubble", 64'(if_valid), 64'd0);
        check("j.addr", 64'(imem_addr), 64'h200);
        clear_redirects();
        step(); check_slot("j.land", 32'h200);

        // backward branch: 0x204 + (-2<<2) = 0x1FC
        br_taken = 1'b1; br_imm = 16'hFFFE;
        step();
        check("br.bubble", 64'(if_valid), 64'd0);
        check("br.addr", 64'(imem_addr), 64'h1FC);
        check("br.misalign", 64'(misalign), 64'd0);
        clear_redirects();
        step(); check_slot("br.land", 32'h1FC);

        // jr wins over jump and branch, misaligned target truncated
        jr = 1'b1; jr_target = 32'h1003; jump = 1'b1; jump_addr = 26'h3FF; br_taken = 1'b1; br_imm = 16'h0040;
        step();
        check("jr.bubble", 64'(if_valid), 64'd0);
        check("jr.addr", 64'(imem_addr), 64'h1000);
        check("jr.misalign", 64'(misalign), 64'd1);
        clear_redirects();
        step();
        check_slot("jr.land", 32'h1000);
        check("jr.misalign_end", 64'(misalign), 64'd0);

        // wrap at top of address space
        jr = 1'b1; jr_target = 32'hFFFF_FFFC;
        step();
        check("wrap.addr", 64'(imem_addr), 64'hFFFF_FFFC);
        check("wrap.misalign", 64'(misalign), 64'd0);
        clear_redirects();
        step();
        check("wrap.if_pc", 64'(if_pc), 64'hFFFF_FFFC);
        check("wrap.pc4", 64'(if_pc_plus4), 64'd0);
        check("wrap.addr0", 64'(imem_addr), 64'd0);
        step(); check_slot("wrap.zero", 32'h0);

        // region jump from if_pc_plus4 = 0x4000_0000
        jr = 1'b1; jr_target = 32'h3FFF_FFFC;
        step(); clear_redirects();
        step(); check_slot("reg.src", 32'h3FFF_FFFC);
        jump = 1'b1; jump_addr = 26'h1;
        step();
        check("reg.addr", 64'(imem_addr), 64'h4000_0004);
        clear_redirects();
        step(); check_slot("reg.land", 32'h4000_0004);

        // halt while stalled, then drain
        id_ready = 1'b0; halt = 1'b1;
        step(); check_slot("halt.hold", 32'h4000_0004);
        halt = 1'b0;
        step(); check_slot("halt.sticky", 32'h4000_0004);
        id_ready = 1'b1;
        step();
        check("halt.drain", 64'(if_valid), 64'd0);
        check("halt.addr", 64'(imem_addr), 64'h4000_0008);
        step(); step();
        check("halt.frozen_v", 64'(if_valid), 64'd0);
        check("halt.frozen_a", 64'(imem_addr), 64'h4000_0008);

        // async reset between edges
        #2 rst_n = 1'b0;
        #1;
        check("arst.valid", 64'(if_valid), 64'd0);
        check("arst.addr", 64'(imem_addr), 64'h100);
        check("arst.if_pc", 64'(if_pc), 64'd0);
        check("arst.pc4", 64'(if_pc_plus4), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        step();
        check("arst.boot", 64'(if_valid), 64'd0);
        step(); check_slot("arst.run", 32'h100);

        // reset during a stall with a redirect pending
        id_ready = 1'b0; jr = 1'b1; jr_target = 32'h5001;
        step();
        #2 rst_n = 1'b0;
        #1;
        check("arst2.valid", 64'(if_valid), 64'd0);
        check("arst2.addr", 64'(imem_addr), 64'h100);
        check("arst2.instr", 64'(if_instr), 64'd0);
        check("arst2.misalign", 64'(misalign), 64'd0);
        clear_redirects();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
